// File: rtl/frame_streamer.sv
// Raster-scans a 64x64 image memory and streams its pixels through a small output FIFO.
// A read is issued only when a FIFO slot is guaranteed for it, so pixels are never dropped.
module frame_streamer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] in_pix,
  output logic [5:0]  row,
  output logic [5:0]  col,
  output logic        we,
  output logic [23:0] m_pix,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [11:0]     addr_q;
  logic            settle_q, rd_q, rd_last_q;
  logic [24:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   occ_q;
  logic            push, pop, issue, last_addr;
  logic [CW:0]     used, limit;

  assign row       = addr_q[11:6];
  assign col       = addr_q[5:0];
  assign last_addr = (addr_q == 12'hfff);
  assign push      = rd_q;
  assign pop       = m_valid & m_ready;
  // A slot freed by this cycle's pop can be re-used by this cycle's read.
  assign used      = {1'b0, occ_q} + {{CW{1'b0}}, rd_q};
  assign limit     = (CW + 1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};
  assign issue     = (state_q == StScan) && !settle_q && (used < limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StScan;
      StScan:  if (issue && last_addr) state_d = StDrain;
      StDrain: if (pop && m_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q == StScan) || (state_q == StDrain);
    frame_done = (state_q == StDone);
    we         = 1'b0;
  end

  // The first SCAN cycle presents address (0,0) before any read is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      settle_q  <= 1'b0;
      rd_q      <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      settle_q  <= (state_q == StIdle) && start;
      rd_q      <= issue;
      rd_last_q <= issue && last_addr;
      if ((state_q == StIdle) && start) addr_q <= '0;
      else if (issue && !last_addr)    addr_q <= addr_q + 12'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {rd_last_q, in_pix};
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      occ_q <= occ_q + CW'(1);
      else if (pop && !push) occ_q <= occ_q - CW'(1);
    end
  end

  assign m_valid = (occ_q != '0);
  assign m_pix   = fifo_q[rd_ptr_q][23:0];
  assign m_last  = fifo_q[rd_ptr_q][24] & m_valid;

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer: behavioural image memories and a raster-order reference sequence.
module tb_frame_streamer;

  localparam int unsigned DEPTH = 4;

  logic        clk, rst;
  logic        start, m_ready, start2, m_ready2;
  logic [23:0] in_pix, in_pix2, m_pix, m_pix2;
  logic [5:0]  row, col, row2, col2;
  logic        we, m_valid, m_last, busy, frame_done;
  logic        we2, m_valid2, m_last2, busy2, frame_done2;

  int n_cmp = 0;
  int n_err = 0;

  frame_streamer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_pix(in_pix), .row(row), .col(col), .we(we),
    .m_pix(m_pix), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy),
    .frame_done(frame_done)
  );

  frame_streamer #(.FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_pix(in_pix2), .row(row2), .col(col2), .we(we2),
    .m_pix(m_pix2), .m_valid(m_valid2), .m_ready(m_ready2), .m_last(m_last2), .busy(busy2),
    .frame_done(frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int r, input int c);
    return {2'b00, 6'(r), 2'b00, 6'(c), 2'b00, 6'(r ^ c)};
  endfunction

  function automatic logic [23:0] pix_at(input int i);
    return pix(i / 64, i % 64);
  endfunction

  // Synchronous-read image memories.
  always @(posedge clk) begin
    in_pix  <= pix(int'(row), int'(col));
    in_pix2 <= pix(int'(row2), int'(col2));
  end

  task automatic test_reset;
    rst = 1'b1; start = 0; start2 = 0; m_ready = 0; m_ready2 = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (row !== 6'd0 || col !== 6'd0 || we !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
        busy !== 1'b0 || frame_done !== 1'b0 || m_pix !== 24'h0) begin
      n_err++;
      $display("FAIL reset: row=%0d col=%0d we=%b v=%b last=%b busy=%b done=%b pix=%h, want all 0",
               row, col, we, m_valid, m_last, busy, frame_done, m_pix);
    end
    n_cmp++;
    if (m_valid2 !== 1'b0 || busy2 !== 1'b0 || m_pix2 !== 24'h0 || we2 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_d2: v=%b busy=%b pix=%h we=%b, want 0", m_valid2, busy2, m_pix2, we2);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input string name, input int pct, input int hold, input bit poke);
    int idx = 0, fd_cnt = 0, first_t = -1, done_t = -1;
    int we_bad = 0, busy_bad = 0, occ_bad = 0;
    logic pv = 0, pr = 0, pl = 0;
    logic [23:0] pp = '0;
    start = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || row !== 6'd0 || col !== 6'd0) begin
      n_err++;
      $display("FAIL %s entry: busy=%b row=%0d col=%0d, want 1 0 0", name, busy, row, col);
    end
    m_ready = ($urandom_range(99) < pct);
    for (int t = 1; t < 20000 && done_t < 0; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (pv && !pr) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_pix !== pp || m_last !== pl) begin
          n_err++;
          $display("FAIL %s stall_hold t=%0d: v=%b pix=%h last=%b, want 1 %h %b",
                   name, t, m_valid, m_pix, m_last, pp, pl);
        end
      end
      if (we !== 1'b0) we_bad++;
      if (frame_done === 1'b1) begin fd_cnt++; done_t = t; end
      else if (busy !== 1'b1) busy_bad++;
      if (m_valid === 1'b1 && first_t < 0) first_t = t;
      if (busy === 1'b1 && {row, col} != 12'hfff && (int'({row, col}) - idx) > int'(DEPTH))
        occ_bad++;
      if (hold > 0 && t == hold) begin
        n_cmp++;
        if (row !== 6'd0 || col !== 6'(DEPTH) || idx != 0 || m_valid !== 1'b1) begin
          n_err++;
          $display("FAIL %s stall_freeze: row=%0d col=%0d acc=%0d v=%b, want 0 %0d 0 1",
                   name, row, col, idx, m_valid, DEPTH);
        end
      end
      m_ready = (t <= hold) ? 1'b0 : ($urandom_range(99) < pct);
      if (poke && (t == 50 || m_last === 1'b1)) start = 1'b1;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        n_cmp++;
        if (m_pix !== pix_at(idx) || m_last !== (idx == 4095)) begin
          n_err++;
          $display("FAIL %s pixel[%0d]: got %h last=%b, want %h last=%b",
                   name, idx, m_pix, m_last, pix_at(idx), (idx == 4095));
        end
        idx++;
      end
      pv = m_valid; pr = m_ready; pp = m_pix; pl = m_last;
    end
    start = 1'b0;
    n_cmp++;
    if (done_t < 0) begin
      n_err++;
      $display("FAIL %s timeout: frame_done never seen, accepted=%0d", name, idx);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (frame_done === 1'b1) fd_cnt++;
      if (busy !== 1'b0) busy_bad++;
    end
    n_cmp++;
    if (idx != 4096 || fd_cnt != 1) begin
      n_err++;
      $display("FAIL %s count: pixels=%0d done_pulses=%0d, want 4096 1", name, idx, fd_cnt);
    end
    n_cmp++;
    if (first_t != 3) begin
      n_err++;
      $display("FAIL %s first_valid: t=%0d, want 3", name, first_t);
    end
    n_cmp++;
    if (we_bad != 0 || busy_bad != 0 || occ_bad != 0) begin
      n_err++;
      $display("FAIL %s flags: we_bad=%0d busy_bad=%0d occ_bad=%0d, want 0 0 0",
               name, we_bad, busy_bad, occ_bad);
    end
    if (pct == 100 && hold == 0) begin
      n_cmp++;
      if (done_t != 4099) begin
        n_err++;
        $display("FAIL %s done_time: t=%0d, want 4099", name, done_t);
      end
    end
  endtask

  task automatic test_stream;
    run_frame("stream", 100, 0, 1'b0);
  endtask

  task automatic test_random_ready;
    run_frame("random_ready", 50, 0, 1'b0);
  endtask

  task automatic test_stall;
    run_frame("stall", 70, 100, 1'b0);
  endtask

  task automatic test_start_ignored;
    run_frame("start_ignored", 100, 0, 1'b1);
  endtask

  task automatic test_reset_mid;
    int idx = 0, bad = 0;
    start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int t = 0; t < 3000 && idx < 2000; t++) begin
      @(posedge clk); #1;
      if (m_valid === 1'b1) begin
        if (m_pix !== pix_at(idx)) bad++;
        idx++;
      end
    end
    n_cmp++;
    if (idx != 2000 || bad != 0) begin
      n_err++;
      $display("FAIL reset_mid prefix: accepted=%0d bad=%0d, want 2000 0", idx, bad);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (row !== 6'd0 || col !== 6'd0 || we !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
        busy !== 1'b0 || frame_done !== 1'b0 || m_pix !== 24'h0) begin
      n_err++;
      $display("FAIL reset_mid async: row=%0d col=%0d v=%b last=%b busy=%b done=%b pix=%h, want 0",
               row, col, m_valid, m_last, busy, frame_done, m_pix);
    end
    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (m_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_mid quiet: %0d cycles with output activity, want 0", bad);
    end
    run_frame("after_reset", 100, 0, 1'b0);
  endtask

  task automatic test_depth2;
    int idx = 0, first_t = -1, done_t = -1, gaps = 0, we_bad = 0;
    start2 = 1'b1; m_ready2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int t = 1; t < 6000 && done_t < 0; t++) begin
      @(posedge clk); #1;
      if (we2 !== 1'b0) we_bad++;
      if (frame_done2 === 1'b1) done_t = t;
      if (m_valid2 === 1'b1 && first_t < 0) first_t = t;
      if (first_t >= 0 && idx < 4096 && m_valid2 !== 1'b1) gaps++;
      if (m_valid2 === 1'b1) begin
        n_cmp++;
        if (m_pix2 !== pix_at(idx) || m_last2 !== (idx == 4095)) begin
          n_err++;
          $display("FAIL depth2 pixel[%0d]: got %h last=%b, want %h last=%b",
                   idx, m_pix2, m_last2, pix_at(idx), (idx == 4095));
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx != 4096 || first_t != 3 || done_t != 4099) begin
      n_err++;
      $display("FAIL depth2 timing: pixels=%0d first=%0d done=%0d, want 4096 3 4099",
               idx, first_t, done_t);
    end
    n_cmp++;
    if (gaps != 0 || we_bad != 0) begin
      n_err++;
      $display("FAIL depth2 throughput: gaps=%0d we_bad=%0d, want 0 0", gaps, we_bad);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_random_ready();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_depth2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
